// File: rtl/pipe_wb_stage.sv
// pipe_wb_stage: MEM->WB pipeline register with valid/ready handshake.
//
// A main register drives the WB outputs. A one-entry skid register catches
// the instruction accepted while WB is stalled, so in_ready can be a plain
// register with no combinational path from out_ready. Also provides the
// writeback result mux and a retired-instruction counter.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   flush               drop every held entry, ignore this cycle's input
//   in_valid/in_ready   MEM-side handshake (in_ready = skid entry empty)
//   RFWEM, MtoRFSelM    MEM-stage RF write enable and result select
//   mem_read, ALU_outM  MEM-stage memory data and ALU result
//   RtDM                MEM-stage destination register
//   out_valid/out_ready WB-side handshake
//   RFWEW, MtoRFSelW    registered write enable (0 on bubbles) and select
//   DMoutW, ALU_outW    registered memory data and ALU result
//   RtDW                registered destination register
//   WB_data             MtoRFSelW ? DMoutW : ALU_outW
//   retire_cnt          output handshakes, wraps modulo 2^CNT_W
module pipe_wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RFWEM,
  input  logic              MtoRFSelM,
  input  logic [DATA_W-1:0] mem_read,
  input  logic [DATA_W-1:0] ALU_outM,
  input  logic [REG_AW-1:0] RtDM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RFWEW,
  output logic              MtoRFSelW,
  output logic [DATA_W-1:0] DMoutW,
  output logic [DATA_W-1:0] ALU_outW,
  output logic [REG_AW-1:0] RtDW,
  output logic [DATA_W-1:0] WB_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef struct packed {
    logic              rfwe;
    logic              sel;
    logic [DATA_W-1:0] dm;
    logic [DATA_W-1:0] alu;
    logic [REG_AW-1:0] rt;
  } entry_t;

  entry_t             in_entry;
  entry_t             main_d, main_q;
  entry_t             skid_d, skid_q;
  logic               out_valid_d, out_valid_q;
  logic               skid_valid_d, skid_valid_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               acc_in, acc_out, main_load;

  assign in_entry = '{rfwe: RFWEM, sel: MtoRFSelM, dm: mem_read, alu: ALU_outM, rt: RtDM};

  assign acc_in    = in_valid & ~skid_valid_q & ~flush;
  assign acc_out   = out_valid_q & out_ready;
  assign main_load = ~out_valid_q | out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    // A handshake seen by the consumer counts even in a flush cycle.
    cnt_d        = cnt_q + CNT_W'(acc_out);

    if (flush) begin
      out_valid_d  = 1'b0;
      main_d.rfwe  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_load) begin
      if (skid_valid_q) begin
        // in_ready is low while skid is full, so no input arrives here.
        main_d       = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (acc_in) begin
        main_d      = in_entry;
        out_valid_d = 1'b1;
      end else begin
        // Bubble: the write enable must never outlive the valid bit.
        out_valid_d = 1'b0;
        main_d.rfwe = 1'b0;
      end
    end else if (acc_in) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      main_q       <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready   = ~skid_valid_q;
  assign out_valid  = out_valid_q;
  assign RFWEW      = main_q.rfwe;
  assign MtoRFSelW  = main_q.sel;
  assign DMoutW     = main_q.dm;
  assign ALU_outW   = main_q.alu;
  assign RtDW       = main_q.rt;
  assign WB_data    = main_q.sel ? main_q.dm : main_q.alu;
  assign retire_cnt = cnt_q;

endmodule
